// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID instruction, forwarding sources, and the EX-side outputs.
interface id_ex_stage_if #(
  parameter int unsigned CTRL_W = 8
);
  // ID side
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [31:0]       id_rdata1;
  logic [31:0]       id_rdata2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  // forwarding sources
  logic              exmem_regwrite;
  logic [4:0]        exmem_wreg;
  logic [31:0]       exmem_result;
  logic              memwb_regwrite;
  logic [4:0]        memwb_wreg;
  logic [31:0]       memwb_wdata;
  // EX side
  logic              stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_wreg;
  logic [31:0]       ex_opA;
  logic [31:0]       ex_opB;
  logic [31:0]       ex_imm;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
           exmem_regwrite, exmem_wreg, exmem_result, memwb_regwrite, memwb_wreg, memwb_wdata,
    input  stall, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_wreg, ex_opA, ex_opB, ex_imm
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
           exmem_regwrite, exmem_wreg, exmem_result, memwb_regwrite, memwb_wreg, memwb_wdata,
    output stall, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_wreg, ex_opA, ex_opB, ex_imm
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, operand forwarding
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W        = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CTRL_MEMREAD = 5;
  localparam int unsigned CTRL_REGDST  = 2;

  logic              valid_q,     valid_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [REG_W-1:0]  rs_q,        rs_d;
  logic [REG_W-1:0]  rt_q,        rt_d;
  logic [REG_W-1:0]  wreg_q,      wreg_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;
  logic [DATA_W-1:0] rdata2_q,    rdata2_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic hz;
  logic exmem_hit_rs, exmem_hit_rt, memwb_hit_rs, memwb_hit_rt;

  // Load-use hazard: the load in EX targets a source of the instruction in ID.
  always_comb begin
    hz = valid_q & ctrl_q[CTRL_MEMREAD] & bus.id_valid & (rt_q != '0) &
         ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    bus.stall = hz & ~bus.flush & ~rst;
  end

  // Next state: flush beats stall beats capture; data fields hold during a bubble.
  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    wreg_d      = wreg_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hz) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      valid_d  = bus.id_valid;
      ctrl_d   = bus.id_valid ? bus.id_ctrl : '0;
      rs_d     = bus.id_rs;
      rt_d     = bus.id_rt;
      wreg_d   = bus.id_ctrl[CTRL_REGDST] ? bus.id_rd : bus.id_rt;
      rdata1_d = bus.id_rdata1;
      rdata2_d = bus.id_rdata2;
      imm_d    = bus.id_imm;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wreg_q      <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wreg_q      <= wreg_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Operand forwarding: EX/MEM over MEM/WB over latched data; $0 never forwarded.
  always_comb begin
    exmem_hit_rs = bus.exmem_regwrite & (bus.exmem_wreg != '0) & (bus.exmem_wreg == rs_q);
    exmem_hit_rt = bus.exmem_regwrite & (bus.exmem_wreg != '0) & (bus.exmem_wreg == rt_q);
    memwb_hit_rs = bus.memwb_regwrite & (bus.memwb_wreg != '0) & (bus.memwb_wreg == rs_q);
    memwb_hit_rt = bus.memwb_regwrite & (bus.memwb_wreg != '0) & (bus.memwb_wreg == rt_q);

    bus.ex_opA = rdata1_q;
    if (memwb_hit_rs) bus.ex_opA = bus.memwb_wdata;
    if (exmem_hit_rs) bus.ex_opA = bus.exmem_result;

    bus.ex_opB = rdata2_q;
    if (memwb_hit_rt) bus.ex_opB = bus.memwb_wdata;
    if (exmem_hit_rt) bus.ex_opB = bus.exmem_result;
  end

  // Registered outputs.
  assign bus.ex_valid = valid_q;
  assign bus.ex_ctrl  = ctrl_q;
  assign bus.ex_rs    = rs_q;
  assign bus.ex_rt    = rt_q;
  assign bus.ex_wreg  = wreg_q;
  assign bus.ex_imm   = imm_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus randomized traffic against a
// behavioural model. A second instance with 2-bit counters exercises saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CTRL_W(8)) bus_a ();
  id_ex_stage_if #(.CTRL_W(8)) bus_b ();

  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  id_ex_stage #(.CTRL_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));
  id_ex_stage #(.CTRL_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  // the saturation instance sees the same stimulus
  assign bus_b.id_valid       = bus_a.id_valid;
  assign bus_b.id_rs          = bus_a.id_rs;
  assign bus_b.id_rt          = bus_a.id_rt;
  assign bus_b.id_rd          = bus_a.id_rd;
  assign bus_b.id_rdata1      = bus_a.id_rdata1;
  assign bus_b.id_rdata2      = bus_a.id_rdata2;
  assign bus_b.id_imm         = bus_a.id_imm;
  assign bus_b.id_ctrl        = bus_a.id_ctrl;
  assign bus_b.flush          = bus_a.flush;
  assign bus_b.exmem_regwrite = bus_a.exmem_regwrite;
  assign bus_b.exmem_wreg     = bus_a.exmem_wreg;
  assign bus_b.exmem_result   = bus_a.exmem_result;
  assign bus_b.memwb_regwrite = bus_a.memwb_regwrite;
  assign bus_b.memwb_wreg     = bus_a.memwb_wreg;
  assign bus_b.memwb_wdata    = bus_a.memwb_wdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [4:0]  m_rs, m_rt, m_wreg;
  logic [31:0] m_rd1, m_rd2, m_imm;
  int          m_stalls, m_flushes;

  function automatic bit m_hazard();
    return m_valid && m_ctrl[5] && bus_a.id_valid && m_rt != 0 &&
           (m_rt == bus_a.id_rs || m_rt == bus_a.id_rt);
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] latched);
    if (bus_a.exmem_regwrite && bus_a.exmem_wreg != 0 && bus_a.exmem_wreg == r)
      return bus_a.exmem_result;
    if (bus_a.memwb_regwrite && bus_a.memwb_wreg != 0 && bus_a.memwb_wreg == r)
      return bus_a.memwb_wdata;
    return latched;
  endfunction

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 0; m_ctrl <= 0; m_rs <= 0; m_rt <= 0; m_wreg <= 0;
      m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_stalls <= 0; m_flushes <= 0;
    end else if (bus_a.flush) begin
      m_valid <= 0; m_ctrl <= 0; m_flushes <= m_flushes + 1;
    end else if (m_hazard()) begin
      m_valid <= 0; m_ctrl <= 0; m_stalls <= m_stalls + 1;
    end else begin
      m_valid <= bus_a.id_valid;
      m_ctrl  <= bus_a.id_valid ? bus_a.id_ctrl : 8'h00;
      m_rs    <= bus_a.id_rs;
      m_rt    <= bus_a.id_rt;
      m_wreg  <= bus_a.id_ctrl[2] ? bus_a.id_rd : bus_a.id_rt;
      m_rd1   <= bus_a.id_rdata1;
      m_rd2   <= bus_a.id_rdata2;
      m_imm   <= bus_a.id_imm;
    end
  end

  // compare both instances against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",     bus_a.stall,    m_hazard() && !bus_a.flush && !rst);
      chk("ex_valid",  bus_a.ex_valid, m_valid);
      chk("ex_ctrl",   bus_a.ex_ctrl,  m_ctrl);
      chk("ex_rs",     bus_a.ex_rs,    m_rs);
      chk("ex_rt",     bus_a.ex_rt,    m_rt);
      chk("ex_wreg",   bus_a.ex_wreg,  m_wreg);
      chk("ex_imm",    bus_a.ex_imm,   m_imm);
      chk("ex_opA",    bus_a.ex_opA,   m_fwd(m_rs, m_rd1));
      chk("ex_opB",    bus_a.ex_opB,   m_fwd(m_rt, m_rd2));
      chk("stall_cnt", stall_cnt_a,    sat(m_stalls, 65535));
      chk("flush_cnt", flush_cnt_a,    sat(m_flushes, 65535));
      chk("sat_stall", bus_b.stall,    bus_a.stall);
      chk("sat_valid", bus_b.ex_valid, m_valid);
      chk("sat_scnt",  stall_cnt_b,    sat(m_stalls, 3));
      chk("sat_fcnt",  flush_cnt_b,    sat(m_flushes, 3));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [7:0] ctrl);
    bus_a.id_valid = v;
    bus_a.id_rs    = rs;
    bus_a.id_rt    = rt;
    bus_a.id_rd    = rd;
    bus_a.id_ctrl  = ctrl;
  endtask

  localparam logic [7:0] CTRL_LW  = 8'hE8; // RegWrite MemtoReg MemRead ALUSrc
  localparam logic [7:0] CTRL_ADD = 8'h86; // RegWrite RegDst ALUOp=10

  initial begin
    rst = 1'b1;
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 8'h00);
    bus_a.id_rdata1 = 0; bus_a.id_rdata2 = 0; bus_a.id_imm = 0; bus_a.flush = 0;
    bus_a.exmem_regwrite = 0; bus_a.exmem_wreg = 0; bus_a.exmem_result = 0;
    bus_a.memwb_regwrite = 0; bus_a.memwb_wreg = 0; bus_a.memwb_wdata = 0;

    // reset
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus_a.ex_valid, 0);
    chk("rst_ctrl",  bus_a.ex_ctrl,  0);
    chk("rst_scnt",  stall_cnt_a,    0);
    chk("rst_fcnt",  flush_cnt_a,    0);

    // capture
    id_set(1'b1, 5'd6, 5'd1, 5'd3, 8'h04);
    bus_a.id_rdata1 = 50; bus_a.id_imm = 32'hFFFF_FFFF;
    cyc();
    bus_a.id_valid = 1'b0;
    @(negedge clk);
    chk("cap_wreg", bus_a.ex_wreg, 3);
    chk("cap_opA",  bus_a.ex_opA,  50);
    chk("cap_imm",  bus_a.ex_imm,  32'hFFFF_FFFF);

    // load-use stall
    id_set(1'b1, 5'd1, 5'd4, 5'd0, CTRL_LW);
    cyc();
    id_set(1'b1, 5'd4, 5'd5, 5'd7, CTRL_ADD);
    @(negedge clk);
    chk("lu_stall", bus_a.stall, 1);
    cyc();
    @(negedge clk);
    chk("lu_stall_clr", bus_a.stall,    0);
    chk("lu_bub_valid", bus_a.ex_valid, 0);
    chk("lu_bub_ctrl",  bus_a.ex_ctrl,  0);
    chk("lu_scnt",      stall_cnt_a,    1);
    cyc();
    bus_a.id_valid = 1'b0;
    @(negedge clk);
    chk("lu_add_valid", bus_a.ex_valid, 1);
    chk("lu_add_ctrl",  bus_a.ex_ctrl,  CTRL_ADD);
    chk("lu_add_wreg",  bus_a.ex_wreg,  7);

    // forwarding
    id_set(1'b1, 5'd2, 5'd3, 5'd9, CTRL_ADD);
    bus_a.id_rdata1 = 100; bus_a.id_rdata2 = 200;
    cyc();
    bus_a.id_valid = 1'b0;
    bus_a.exmem_regwrite = 1; bus_a.exmem_wreg = 2; bus_a.exmem_result = 7;
    bus_a.memwb_regwrite = 1; bus_a.memwb_wreg = 2; bus_a.memwb_wdata = 9;
    #1 chk("fwd_exmem", bus_a.ex_opA, 7);
    bus_a.exmem_regwrite = 0;
    #1 chk("fwd_memwb", bus_a.ex_opA, 9);
    bus_a.exmem_regwrite = 1; bus_a.exmem_wreg = 0; bus_a.memwb_wreg = 0;
    #1 chk("fwd_r0", bus_a.ex_opA, 100);
    bus_a.exmem_wreg = 3;
    #1 chk("fwd_opB", bus_a.ex_opB, 7);
    bus_a.exmem_regwrite = 0; bus_a.exmem_wreg = 0; bus_a.memwb_regwrite = 0;

    // flush during hazard
    id_set(1'b1, 5'd1, 5'd4, 5'd0, CTRL_LW);
    cyc();
    id_set(1'b1, 5'd4, 5'd5, 5'd7, CTRL_ADD);
    bus_a.flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", bus_a.stall, 0);
    cyc();
    bus_a.flush = 1'b0; bus_a.id_valid = 1'b0;
    @(negedge clk);
    chk("fl_valid", bus_a.ex_valid, 0);
    chk("fl_ctrl",  bus_a.ex_ctrl,  0);
    chk("fl_fcnt",  flush_cnt_a,    1);
    chk("fl_scnt",  stall_cnt_a,    1);

    // saturation on the 2-bit instance
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus_a.flush = 1'b1;
    repeat (5) cyc();
    bus_a.flush = 1'b0;
    @(negedge clk);
    chk("sat_fcnt3", flush_cnt_b, 3);
    chk("sat_fcnt5", flush_cnt_a, 5);

    // reset in the middle of a stall
    id_set(1'b1, 5'd1, 5'd4, 5'd0, CTRL_LW);
    cyc();
    id_set(1'b1, 5'd4, 5'd5, 5'd7, CTRL_ADD);
    cyc();
    id_set(1'b1, 5'd1, 5'd4, 5'd0, CTRL_LW);
    cyc();
    id_set(1'b1, 5'd4, 5'd5, 5'd7, CTRL_ADD);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_stall", bus_a.stall, 0);
    cyc();
    rst = 1'b0; bus_a.id_valid = 1'b0;
    @(negedge clk);
    chk("mr_valid", bus_a.ex_valid, 0);
    chk("mr_scnt",  stall_cnt_a,    0);
    chk("mr_fcnt",  flush_cnt_a,    0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      bus_a.flush = ($urandom_range(0, 9) == 0);
      id_set(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 8'($urandom));
      bus_a.id_rdata1 = $urandom; bus_a.id_rdata2 = $urandom; bus_a.id_imm = $urandom;
      bus_a.exmem_regwrite = 1'($urandom); bus_a.exmem_wreg = 5'($urandom_range(0, 7));
      bus_a.exmem_result = $urandom;
      bus_a.memwb_regwrite = 1'($urandom); bus_a.memwb_wreg = 5'($urandom_range(0, 7));
      bus_a.memwb_wdata = $urandom;
    end

    cyc();
    rst = 1'b0; bus_a.flush = 1'b0; bus_a.id_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
